dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256-bit data memory between two requesters: the ASIP memory stage (CPU port) and the debug/result-dump port (DBG port).
- Arbitrates with fixed CPU priority plus a starvation guard for DBG.
- Sequences multi-cycle reads using a fixed memory read latency.
- Produces the BusyDA stall seen by the memory stage and hazard unit.

Parameters:
- V, 256, data width in bits (one vector line).
- A, 14, word address width.
- BE, 32, byte-enable width (V/8).
- RDLAT, 1, memory read latency in cycles; legal range 1..3.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which DBG wins once; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_rden  in  1  CPU read request; held stable while cpu_busy=1.
- cpu_wren  in  1  CPU write request; held stable while cpu_busy=1.
- cpu_address  in  A  CPU word address.
- cpu_byteena  in  BE  CPU byte enables.
- cpu_wdata  in  V  CPU write data.
- cpu_busy  out  1  stall to memory stage (BusyDA).
- cpu_rdata  out  V  CPU read data.
- cpu_rvalid  out  1  CPU read complete, 1-cycle pulse.
- dbg_req  in  1  DBG request; held stable until dbg_gnt.
- dbg_we  in  1  DBG is a write (1) or a read (0).
- dbg_address  in  A  DBG word address.
- dbg_byteena  in  BE  DBG byte enables.
- dbg_wdata  in  V  DBG write data.
- dbg_gnt  out  1  DBG request accepted, 1-cycle pulse.
- dbg_rdata  out  V  DBG read data.
- dbg_rvalid  out  1  DBG read complete, 1-cycle pulse.
- mem_rden  out  1  memory read strobe.
- mem_wren  out  1  memory write strobe.
- mem_address  out  A  memory address.
- mem_byteena  out  BE  memory byte enables.
- mem_wdata  out  V  memory write data.
- mem_rdata  in  V  memory read data; valid exactly RDLAT cycles after the mem_rden cycle.

Behaviour:
- States:
  - IDLE: arbitrate.
  - RD_CPU: CPU read in flight.
  - RD_DBG: DBG read in flight.
  - Wait counter is ceil(log2(RDLAT+1)) bits.
- Reset values:
  - State IDLE; wait counter 0; starve_cnt 0.
  - cpu_rdata and dbg_rdata registers 0.
  - mem_rden, mem_wren, dbg_gnt, cpu_rvalid, dbg_rvalid all 0.
  - mem_address, mem_byteena, mem_wdata all 0.
  - cpu_busy = cpu_rden|cpu_wren while rst=1, so the CPU is held off.
- Definitions: cpu_req = cpu_rden|cpu_wren. If cpu_rden and cpu_wren are both 1, the access is a write only; no read is issued and no cpu_rvalid follows.
- IDLE arbitration (combinational issue, same cycle):
  - DBG wins if dbg_req & (~cpu_req | starve_cnt==STARVE_LIMIT). Otherwise CPU wins if cpu_req.
  - The winner's address, byteena and wdata drive mem_*. mem_wren = winner is writing; mem_rden = winner is reading.
  - With no winner, all mem_* are 0.
- CPU write: completes in the issue cycle. cpu_busy=0 that cycle; state stays IDLE.
- CPU read:
  - Issue cycle: cpu_busy=1; next state RD_CPU, counter=RDLAT.
  - RD_CPU: mem_rden=0, no new issue; counter decrements each cycle.
  - The cycle where mem_rdata is valid (counter==1) is the completion cycle: cpu_busy=0, cpu_rvalid=1, cpu_rdata = mem_rdata (pass-through), and the value is registered.
  - Next state IDLE; cpu_rdata then holds the registered value until the next CPU read completes.
  - CPU read latency from issue to data = RDLAT cycles, so cpu_busy is high for RDLAT cycles.
- Any CPU request not being issued or completed this cycle gives cpu_busy=1. This includes losing to DBG or DBG being in flight.
- DBG write: dbg_gnt=1 in the issue cycle; done.
- DBG read: dbg_gnt=1 in the issue cycle, then RD_DBG, mirroring RD_CPU. dbg_rvalid and dbg_rdata appear in the completion cycle; dbg_rdata is held afterwards.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) in each IDLE cycle where dbg_req=1 and CPU wins.
  - Clears when DBG is granted or dbg_req=0.
  - Holds in RD_* states.
- Only one access is ever in flight; there is no read pipelining.
- Back-to-back: completion cycle → IDLE next cycle → new issue possible in that cycle, so the minimum read-to-read spacing is RDLAT+1 cycles.
- Reset mid-read: the in-flight read is abandoned. No rvalid is asserted; the state returns to IDLE on the reset edge.
- Address/data widths pass straight through; no arithmetic on addresses.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cpu_wren=1 → mem_wren=0, cpu_busy=1, dbg_gnt=0, both rvalid=0. Release → write issues on the first post-reset cycle.
- CPU write: address 0x0010, byteena 0xFFFFFFFF, wdata {8{32'hA5A5_0000+i}} → same cycle mem_wren=1, mem_address=0x0010, cpu_busy=0. Next cycle mem_wren=0.
- CPU read, RDLAT=2, memory model returns 256'h…DEADBEEF for 0x0010 → cpu_busy=1 for 2 cycles. Third cycle: cpu_rvalid=1, cpu_rdata=…DEADBEEF, cpu_busy=0. Value held afterwards.
- Contention: CPU and DBG both issue continuous reads, RDLAT=1, STARVE_LIMIT=4 → CPU wins 4 IDLE arbitrations, DBG is granted on the 5th. cpu_busy stays high through the DBG read; starve_cnt returns to 0.
- Reset mid-read: rst asserted in the RD_CPU cycle → no cpu_rvalid. Next cycle state IDLE and mem_rden=0.
- Illegal combo: cpu_rden=cpu_wren=1 at address 0x0020 → mem_wren=1, mem_rden=0, cpu_busy=0 in the same cycle, no cpu_rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory stage and the debug port
module dmem_arbiter #(
    parameter int V            = 256,
    parameter int A            = 14,
    parameter int BE           = 32,
    parameter int RDLAT        = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rden,
    input  logic          cpu_wren,
    input  logic [A-1:0]  cpu_address,
    input  logic [BE-1:0] cpu_byteena,
    input  logic [V-1:0]  cpu_wdata,
    output logic          cpu_busy,
    output logic [V-1:0]  cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [A-1:0]  dbg_address,
    input  logic [BE-1:0] dbg_byteena,
    input  logic [V-1:0]  dbg_wdata,
    output logic          dbg_gnt,
    output logic [V-1:0]  dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic [A-1:0]  mem_address,
    output logic [BE-1:0] mem_byteena,
    output logic [V-1:0]  mem_wdata,
    input  logic [V-1:0]  mem_rdata
);
    localparam int CW = $clog2(RDLAT + 1);

    typedef enum logic [1:0] {IDLE, RD_CPU, RD_DBG} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic [V-1:0]  cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic          cpu_req, cpu_rd, dbg_win, cpu_win, done;

    // a simultaneous read+write from the CPU is treated as a write only
    assign cpu_req = cpu_rden | cpu_wren;
    assign cpu_rd  = cpu_rden & ~cpu_wren;
    assign dbg_win = (state_q == IDLE) & dbg_req & (~cpu_req | (starve_q == 4'(STARVE_LIMIT)));
    assign cpu_win = (state_q == IDLE) & ~dbg_win & cpu_req;
    assign done    = (cnt_q == CW'(1));

    // arbitration, memory strobes, read completion and next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_rdata   = cpu_rdata_q;
        dbg_rdata   = dbg_rdata_q;
        cpu_busy    = cpu_req;
        cpu_rvalid  = 1'b0;
        dbg_rvalid  = 1'b0;
        dbg_gnt     = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_address = '0;
        mem_byteena = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (dbg_win) begin
                    mem_address = dbg_address;
                    mem_byteena = dbg_byteena;
                    mem_wdata   = dbg_wdata;
                    mem_wren    = dbg_we;
                    mem_rden    = ~dbg_we;
                    dbg_gnt     = 1'b1;
                    starve_d    = '0;
                    state_d     = dbg_we ? IDLE : RD_DBG;
                    cnt_d       = CW'(RDLAT);
                end else if (cpu_win) begin
                    mem_address = cpu_address;
                    mem_byteena = cpu_byteena;
                    mem_wdata   = cpu_wdata;
                    mem_wren    = cpu_wren;
                    mem_rden    = cpu_rd;
                    cpu_busy    = cpu_rd;
                    starve_d    = !dbg_req ? 4'd0 : (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
                    state_d     = cpu_rd ? RD_CPU : IDLE;
                    cnt_d       = CW'(RDLAT);
                end else begin
                    starve_d = '0;
                end
            end
            RD_CPU: begin
                cnt_d = cnt_q - CW'(1);
                if (done) begin
                    cpu_busy    = 1'b0;
                    cpu_rvalid  = 1'b1;
                    cpu_rdata   = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                    state_d     = IDLE;
                end
            end
            RD_DBG: begin
                cnt_d = cnt_q - CW'(1);
                if (done) begin
                    dbg_rvalid  = 1'b1;
                    dbg_rdata   = mem_rdata;
                    dbg_rdata_d = mem_rdata;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            cpu_busy    = cpu_req;
            cpu_rvalid  = 1'b0;
            dbg_rvalid  = 1'b0;
            dbg_gnt     = 1'b0;
            mem_rden    = 1'b0;
            mem_wren    = 1'b0;
            mem_address = '0;
            mem_byteena = '0;
            mem_wdata   = '0;
        end
    end

    // state, wait counter, starvation counter and held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, read sequencing and reset behaviour
module tb_dmem_arbiter;
    localparam int V = 256, A = 14, BE = 32;

    logic          clk = 1'b0, rst;
    logic          cpu_rden, cpu_wren, dbg_req, dbg_we;
    logic [A-1:0]  cpu_address, dbg_address;
    logic [BE-1:0] cpu_byteena, dbg_byteena;
    logic [V-1:0]  cpu_wdata, dbg_wdata, wpat;

    logic          cpu_busy, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_rden, mem_wren;
    logic [V-1:0]  cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [A-1:0]  mem_address;
    logic [BE-1:0] mem_byteena;

    logic          cpu_busy1, cpu_rvalid1, dbg_gnt1, dbg_rvalid1, mem_rden1, mem_wren1;
    logic [V-1:0]  cpu_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
    logic [A-1:0]  mem_address1;
    logic [BE-1:0] mem_byteena1;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [V-1:0] mem_val(input logic [A-1:0] a);
        mem_val = {{7{18'h0, a}}, 32'hDEADBEEF};
    endfunction

    // memory models: data valid exactly RDLAT cycles after the read strobe, zero otherwise
    logic [1:0]   v2;
    logic [A-1:0] a2 [2];
    logic         v1;
    logic [A-1:0] a1;
    always @(posedge clk) begin
        v2    <= {v2[0], mem_rden};
        a2[0] <= mem_address;
        a2[1] <= a2[0];
        v1    <= mem_rden1;
        a1    <= mem_address1;
    end
    assign mem_rdata  = (v2[1] === 1'b1) ? mem_val(a2[1]) : '0;
    assign mem_rdata1 = (v1 === 1'b1) ? mem_val(a1) : '0;

    dmem_arbiter #(.RDLAT(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
        .cpu_byteena(cpu_byteena), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
        .dbg_byteena(dbg_byteena), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_byteena(mem_byteena), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.RDLAT(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
        .cpu_byteena(cpu_byteena), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy1), .cpu_rdata(cpu_rdata1), .cpu_rvalid(cpu_rvalid1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
        .dbg_byteena(dbg_byteena), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt1), .dbg_rdata(dbg_rdata1), .dbg_rvalid(dbg_rvalid1),
        .mem_rden(mem_rden1), .mem_wren(mem_wren1), .mem_address(mem_address1),
        .mem_byteena(mem_byteena1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) wpat[i*32 +: 32] = 32'hA5A5_0000 + i;
        rst = 1'b1; cpu_rden = 1'b0; cpu_wren = 1'b1; cpu_address = 14'h0010;
        cpu_byteena = '1; cpu_wdata = wpat;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_address = '0; dbg_byteena = '0; dbg_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            n_checks++;
            if ({mem_wren, cpu_busy, dbg_gnt, cpu_rvalid, dbg_rvalid} !== 5'b01000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b exp 01000", i, {mem_wren, cpu_busy, dbg_gnt, cpu_rvalid, dbg_rvalid});
            end
        end
        n_checks++;
        if (cpu_rdata !== '0 || mem_address !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: cpu_rdata %h mem_address %h exp 0", cpu_rdata, mem_address);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_wren, cpu_busy} !== 2'b10 || mem_address !== 14'h0010) begin
            n_fail++;
            $display("FAIL post_reset_write: wren/busy %b addr %h exp 10 / 0010", {mem_wren, cpu_busy}, mem_address);
        end
    endtask

    task automatic test_cpu_write();
        tick();
        cpu_wren = 1'b1; cpu_address = 14'h0010;
        @(negedge clk);
        n_checks++;
        if ({mem_wren, mem_rden, cpu_busy} !== 3'b100 || mem_address !== 14'h0010 ||
            mem_wdata !== wpat || mem_byteena !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL cpu_write: wren/rden/busy %b addr %h be %h exp 100 0010 ffffffff", {mem_wren, mem_rden, cpu_busy}, mem_address, mem_byteena);
        end
        tick();
        cpu_wren = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_wren, cpu_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_write_end: wren/busy %b exp 00", {mem_wren, cpu_busy});
        end
    endtask

    task automatic test_cpu_read();
        tick();
        cpu_rden = 1'b1; cpu_address = 14'h0010;
        @(negedge clk);
        n_checks++;
        if ({mem_rden, cpu_busy, cpu_rvalid} !== 3'b110 || mem_address !== 14'h0010) begin
            n_fail++;
            $display("FAIL cpu_read_issue: rden/busy/rvalid %b addr %h exp 110 0010", {mem_rden, cpu_busy, cpu_rvalid}, mem_address);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({mem_rden, cpu_busy, cpu_rvalid} !== 3'b010) begin
            n_fail++;
            $display("FAIL cpu_read_wait: rden/busy/rvalid %b exp 010", {mem_rden, cpu_busy, cpu_rvalid});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({cpu_busy, cpu_rvalid} !== 2'b01 || cpu_rdata !== mem_val(14'h0010)) begin
            n_fail++;
            $display("FAIL cpu_read_done: busy/rvalid %b rdata %h exp 01 %h", {cpu_busy, cpu_rvalid}, cpu_rdata, mem_val(14'h0010));
        end
        tick();
        cpu_rden = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_busy, cpu_rvalid} !== 2'b00 || cpu_rdata !== mem_val(14'h0010)) begin
            n_fail++;
            $display("FAIL cpu_read_hold: busy/rvalid %b rdata %h exp 00 %h", {cpu_busy, cpu_rvalid}, cpu_rdata, mem_val(14'h0010));
        end
    endtask

    task automatic test_dbg_read();
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_address = 14'h0030;
        @(negedge clk);
        n_checks++;
        if ({dbg_gnt, mem_rden, mem_wren} !== 3'b110 || mem_address !== 14'h0030) begin
            n_fail++;
            $display("FAIL dbg_read_issue: gnt/rden/wren %b addr %h exp 110 0030", {dbg_gnt, mem_rden, mem_wren}, mem_address);
        end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dbg_gnt, dbg_rvalid, mem_rden} !== 3'b000) begin
            n_fail++;
            $display("FAIL dbg_read_wait: gnt/rvalid/rden %b exp 000", {dbg_gnt, dbg_rvalid, mem_rden});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== mem_val(14'h0030)) begin
            n_fail++;
            $display("FAIL dbg_read_done: rvalid %b rdata %h exp 1 %h", dbg_rvalid, dbg_rdata, mem_val(14'h0030));
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== mem_val(14'h0030)) begin
            n_fail++;
            $display("FAIL dbg_read_hold: rvalid %b rdata %h exp 0 %h", dbg_rvalid, dbg_rdata, mem_val(14'h0030));
        end
    endtask

    task automatic test_contention();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_rden = 1'b1; cpu_address = 14'h0040;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_address = 14'h0050;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            n_checks++;
            if (i % 2 == 0) begin
                if ({mem_rden1, dbg_gnt1, cpu_busy1} !== 3'b101 || mem_address1 !== 14'h0040) begin
                    n_fail++;
                    $display("FAIL contention_cpu_issue %0d: rden/gnt/busy %b addr %h exp 101 0040", i, {mem_rden1, dbg_gnt1, cpu_busy1}, mem_address1);
                end
            end else begin
                if ({cpu_rvalid1, cpu_busy1, dbg_gnt1} !== 3'b100 || cpu_rdata1 !== mem_val(14'h0040)) begin
                    n_fail++;
                    $display("FAIL contention_cpu_done %0d: rvalid/busy/gnt %b rdata %h", i, {cpu_rvalid1, cpu_busy1, dbg_gnt1}, cpu_rdata1);
                end
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({dbg_gnt1, mem_rden1, cpu_busy1} !== 3'b111 || mem_address1 !== 14'h0050) begin
            n_fail++;
            $display("FAIL contention_dbg_grant: gnt/rden/busy %b addr %h exp 111 0050", {dbg_gnt1, mem_rden1, cpu_busy1}, mem_address1);
        end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dbg_rvalid1, cpu_busy1, cpu_rvalid1} !== 3'b110 || dbg_rdata1 !== mem_val(14'h0050) || u_dut1.starve_q !== 4'd0) begin
            n_fail++;
            $display("FAIL contention_dbg_done: rvalid/busy/crvalid %b rdata %h starve %0d exp 110 0", {dbg_rvalid1, cpu_busy1, cpu_rvalid1}, dbg_rdata1, u_dut1.starve_q);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({mem_rden1, dbg_gnt1} !== 2'b10 || mem_address1 !== 14'h0040) begin
            n_fail++;
            $display("FAIL contention_cpu_resume: rden/gnt %b addr %h exp 10 0040", {mem_rden1, dbg_gnt1}, mem_address1);
        end
        tick();
        cpu_rden = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        cpu_rden = 1'b1; cpu_address = 14'h0010;
        @(negedge clk);
        n_checks++;
        if (mem_rden !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_issue: rden %b exp 1", mem_rden);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, mem_rden, cpu_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL midrd_reset: rvalid/rden/busy %b exp 001", {cpu_rvalid, mem_rden, cpu_busy});
        end
        tick();
        rst = 1'b0;
        cpu_rden = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, mem_rden, cpu_busy} !== 3'b000 || u_dut.state_q !== 2'd0) begin
            n_fail++;
            $display("FAIL midrd_after: rvalid/rden/busy %b state %0d exp 000 0", {cpu_rvalid, mem_rden, cpu_busy}, u_dut.state_q);
        end
    endtask

    task automatic test_illegal();
        tick();
        cpu_rden = 1'b1; cpu_wren = 1'b1; cpu_address = 14'h0020;
        @(negedge clk);
        n_checks++;
        if ({mem_wren, mem_rden, cpu_busy} !== 3'b100 || mem_address !== 14'h0020) begin
            n_fail++;
            $display("FAIL illegal_issue: wren/rden/busy %b addr %h exp 100 0020", {mem_wren, mem_rden, cpu_busy}, mem_address);
        end
        tick();
        cpu_rden = 1'b0; cpu_wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            n_checks++;
            if ({cpu_rvalid, mem_rden, mem_wren} !== 3'b000) begin
                n_fail++;
                $display("FAIL illegal_no_rvalid %0d: rvalid/rden/wren %b exp 000", i, {cpu_rvalid, mem_rden, mem_wren});
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_dbg_read();
        test_contention();
        test_reset_mid_read();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
